// File: rtl/counter_mod10.sv
// One BCD digit of the microwave timer: loadable, enable-controlled modulo-10 down-counter.
// Optional build macro COUNTER_MOD10_SATURATE_LOAD_EN: out-of-range loads store 9 instead of 0.
module counter_mod10 #(
    parameter int RESET_VALUE = 0
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       enable,
    output logic [3:0] digit,
    output logic       tc,
    output logic       zero
);

    // An illegal RESET_VALUE falls back to 0 so the digit can never start above 9.
    localparam logic [3:0] RESET_DIGIT =
        (RESET_VALUE >= 0 && RESET_VALUE <= 9) ? 4'(RESET_VALUE) : 4'd0;

`ifdef COUNTER_MOD10_SATURATE_LOAD_EN
    localparam logic [3:0] OOR_LOAD = 4'd9;
`else
    localparam logic [3:0] OOR_LOAD = 4'd0;
`endif

    logic [3:0] digit_q;
    logic [3:0] digit_d;
    logic [3:0] load_value;

    always_comb begin
        load_value = data;
        if (data > 4'd9) begin
            load_value = OOR_LOAD;
        end
    end

    // Load beats count; count wraps 0 -> 9.
    always_comb begin
        digit_d = digit_q;
        if (!loadn) begin
            digit_d = load_value;
        end else if (enable) begin
            digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            digit_q <= RESET_DIGIT;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;
    assign zero  = (digit_q == 4'd0);
    assign tc    = zero & enable;

endmodule

// File: tb/tb_counter_mod10.sv
// Self-checking bench for counter_mod10: directed steps then randomized traffic vs. an arithmetic model.
// Honours COUNTER_MOD10_SATURATE_LOAD_EN to pick the expected out-of-range load value.
module tb_counter_mod10;

    logic       clock;
    logic       clear;
    logic [3:0] data;
    logic       loadn;
    logic       enable;
    logic [3:0] digit;
    logic       tc;
    logic       zero;

    int checks = 0;
    int errors = 0;
    int model  = 0;

`ifdef COUNTER_MOD10_SATURATE_LOAD_EN
    localparam int OOR_EXPECT = 9;
`else
    localparam int OOR_EXPECT = 0;
`endif

    counter_mod10 #(.RESET_VALUE(0)) dut (
        .clock (clock),
        .clear (clear),
        .data  (data),
        .loadn (loadn),
        .enable(enable),
        .digit (digit),
        .tc    (tc),
        .zero  (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOne(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model value and current enable.
    task automatic checkOutput(input string tag);
        checkOne({tag, ".digit"}, digit, 4'(model));
        checkOne({tag, ".zero"}, {3'b0, zero}, {3'b0, model == 0});
        checkOne({tag, ".tc"}, {3'b0, tc}, {3'b0, (model == 0) && enable});
    endtask

    // Drive inputs on the falling edge; clear takes effect at once.
    task automatic applyStimulus(input logic c, input logic ld, input logic [3:0] d, input logic en);
        @(negedge clock);
        clear  = c;
        loadn  = ld;
        data   = d;
        enable = en;
        #1;
        if (c) model = 0;
    endtask

    // One rising edge, then advance the model from the held inputs.
    task automatic stepEdge();
        @(posedge clock);
        #1;
        if (clear)       model = 0;
        else if (!loadn) model = (data > 9) ? OOR_EXPECT : int'(data);
        else if (enable) model = (model + 9) % 10;
    endtask

    int seq [8] = '{5, 4, 3, 2, 1, 0, 9, 8};

    initial begin
        clear = 1'b1; loadn = 1'b1; enable = 1'b0; data = 4'd0;

        // Reset held for two cycles
        applyStimulus(1'b1, 1'b1, 4'd0, 1'b0);
        stepEdge();
        stepEdge();
        checkOutput("reset");

        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1);
        checkOne("release_tc", {3'b0, tc}, 4'd1);
        stepEdge();
        checkOne("first_wrap", digit, 4'd9);
        checkOutput("first_wrap");

        // Load 6 and hold
        applyStimulus(1'b0, 1'b0, 4'd6, 1'b0);
        stepEdge();
        checkOne("load6", digit, 4'd6);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b0);
        stepEdge();
        stepEdge();
        checkOne("hold6", digit, 4'd6);

        // Count down through the wrap
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            stepEdge();
            checkOne("wrapseq", digit, 4'(seq[i]));
            checkOutput("wrapseq");
        end

        // Load beats enable
        applyStimulus(1'b0, 1'b0, 4'd3, 1'b0);
        stepEdge();
        applyStimulus(1'b0, 1'b0, 4'd7, 1'b1);
        stepEdge();
        checkOne("load_over_enable", digit, 4'd7);
        applyStimulus(1'b0, 1'b1, 4'd0, 1'b1);
        stepEdge();
        checkOne("after_load", digit, 4'd6);

        // Async clear mid-count at digit 4
        stepEdge();
        stepEdge();
        checkOne("at4", digit, 4'd4);
        #2;
        clear = 1'b1;
        model = 0;
        #1;
        checkOne("async_clear", digit, 4'd0);
        applyStimulus(1'b1, 1'b0, 4'd5, 1'b1);
        stepEdge();
        checkOne("clear_dominates", digit, 4'd0);
        checkOutput("clear_dominates");

        // Out-of-range load
        applyStimulus(1'b0, 1'b0, 4'd12, 1'b0);
        stepEdge();
        checkOne("oor_load", digit, 4'(OOR_EXPECT));
        checkOutput("oor_load");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 5) != 0),
                          4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)));
            checkOutput("rand_pre");
            stepEdge();
            checkOutput("rand_post");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
